// File: rtl/mem_copy_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_ctrl_pkg
// Shared definitions for the ROM-to-SRAM block-copy engine.
//   - state_t      : FSM state encoding (IDLE / READ / WRITE / DONE)
//   - ROM_REGION   : region code driven on mem_addr[6:5] for reads
//   - SRAM_REGION  : region code driven on mem_addr[6:5] for writes
//   - MAX_LEN      : largest legal copy length (one full bank)
//   - field widths of the 7-bit memory address {region, bank, offset}
//   - len_legal()  : start-command length check
//   - make_addr()  : memory address assembly
// -----------------------------------------------------------------------------
package mem_copy_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int REGION_W    = 2;
    // Bank index width on the command interface.
    localparam int BANK_W      = 3;
    // Bank field width inside the 7-bit address; the command index is
    // truncated to this many low bits.
    localparam int ADDR_BANK_W = 2;
    localparam int OFF_W       = 3;
    localparam int ADDR_W      = REGION_W + ADDR_BANK_W + OFF_W;
    localparam int DATA_W      = 8;
    localparam int LEN_W       = 4;

    localparam logic [REGION_W-1:0] ROM_REGION  = 2'b00;
    localparam logic [REGION_W-1:0] SRAM_REGION = 2'b10;
    localparam logic [LEN_W-1:0]    MAX_LEN     = 4'd8;

    // A copy must move at least one byte and never more than one bank.
    function automatic logic len_legal(input logic [LEN_W-1:0] l);
        return (l != 4'd0) && (l <= MAX_LEN);
    endfunction

    // Assemble {region, bank, offset}.
    function automatic logic [ADDR_W-1:0] make_addr(
        input logic [REGION_W-1:0]    region,
        input logic [ADDR_BANK_W-1:0] bank,
        input logic [OFF_W-1:0]       off
    );
        return {region, bank, off};
    endfunction

endpackage

// File: rtl/mem_copy_ctrl.sv
// -----------------------------------------------------------------------------
// mem_copy_ctrl
// Block-copy engine in front of the 128-entry ROM/SRAM memory map. A legal
// start copies len consecutive bytes from a ROM bank into an SRAM bank, one
// READ cycle followed by one WRITE cycle per byte, and reports the modulo-256
// sum of the bytes written.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  copy request, sampled only while idle
//   src_bank  in   3  ROM bank index (low 2 bits reach mem_addr[4:3])
//   dst_bank  in   3  SRAM bank index (low 2 bits reach mem_addr[4:3])
//   len       in   4  bytes to copy, legal 1..MAX_LEN
//   mem_dout  in   8  memory read data, combinational on mem_addr
//   mem_addr  out  7  memory address {region, bank, offset}
//   mem_we    out  1  memory write enable
//   mem_din   out  8  memory write data
//   busy      out  1  high during READ and WRITE
//   done      out  1  one-cycle pulse at copy completion
//   err       out  1  one-cycle pulse when a start is rejected
//   checksum  out  8  running modulo-256 sum of bytes written
// -----------------------------------------------------------------------------
module mem_copy_ctrl
    import mem_copy_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BANK_W-1:0]   src_bank,
    input  logic [BANK_W-1:0]   dst_bank,
    input  logic [LEN_W-1:0]    len,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_din,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   checksum
);

    state_t                 state_r;
    logic [ADDR_BANK_W-1:0] src_r;
    logic [ADDR_BANK_W-1:0] dst_r;
    logic [LEN_W-1:0]       len_r;
    logic [OFF_W-1:0]       off_r;
    logic [DATA_W-1:0]      data_r;
    logic                   last_s;
    logic                   unused_bank_bits_s;

    // The address has only a 2-bit bank field; the top bank bit is dropped.
    assign unused_bank_bits_s = src_bank[2] ^ dst_bank[2];

    // The byte being written is the final one of this copy.
    assign last_s = ({1'b0, off_r} == (len_r - 4'd1));

    // Copy FSM with datapath registers; every output is assigned here so the
    // memory port and status flags change only on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            src_r    <= 2'd0;
            dst_r    <= 2'd0;
            len_r    <= 4'd0;
            off_r    <= 3'd0;
            data_r   <= 8'd0;
            mem_addr <= 7'd0;
            mem_we   <= 1'b0;
            mem_din  <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            checksum <= 8'd0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (len_legal(len)) begin
                            src_r    <= src_bank[1:0];
                            dst_r    <= dst_bank[1:0];
                            len_r    <= len;
                            off_r    <= 3'd0;
                            checksum <= 8'd0;
                            // Present the first ROM address for the READ cycle.
                            mem_addr <= make_addr(ROM_REGION, src_bank[1:0], 3'd0);
                            mem_we   <= 1'b0;
                            busy     <= 1'b1;
                            state_r  <= ST_READ;
                        end else begin
                            // Rejected: no memory access, checksum untouched.
                            err     <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_READ: begin
                    // mem_dout reflects the ROM address presented this cycle.
                    data_r   <= mem_dout;
                    mem_din  <= mem_dout;
                    mem_addr <= make_addr(SRAM_REGION, dst_r, off_r);
                    mem_we   <= 1'b1;
                    busy     <= 1'b1;
                    state_r  <= ST_WRITE;
                end

                ST_WRITE: begin
                    // The memory captures mem_din on this same edge.
                    checksum <= checksum + data_r;
                    off_r    <= off_r + 3'd1;
                    mem_we   <= 1'b0;
                    if (last_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        mem_addr <= make_addr(ROM_REGION, src_r, off_r + 3'd1);
                        busy     <= 1'b1;
                        state_r  <= ST_READ;
                    end
                end

                ST_DONE: begin
                    // Starts arriving here are ignored; the checksum holds.
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_ctrl
// Bench for mem_copy_ctrl with the 128-byte memory map downstream. ROM bank b
// word j holds fib(j)+b; everything else starts at 8'hEE. For every accepted
// start the bench lists the per-cycle outputs the copy must produce (a READ
// and a WRITE per byte, then one DONE cycle) and a reference image of memory.
// -----------------------------------------------------------------------------
module tb_mem_copy_ctrl;

    typedef struct {
        logic [6:0] addr;
        logic       chk_addr;
        logic       we;
        logic [7:0] din;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] ck;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] src_bank;
    logic [2:0] dst_bank;
    logic [3:0] len;
    logic [7:0] mem_dout;
    logic [6:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_din;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] checksum;

    logic [7:0] mem     [0:127];
    logic [7:0] exp_mem [0:127];
    logic [6:0] tb_addr;
    logic [6:0] m_addr;
    logic       m_we;

    exp_t exp_q[$];
    exp_t cur_e;
    logic [7:0] idle_ck;
    int total;
    int bad;
    int done_cnt;

    mem_copy_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_bank (src_bank),
        .dst_bank (dst_bank),
        .len      (len),
        .mem_dout (mem_dout),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory map: port belongs to the engine while busy, else to the bench.
    assign m_addr   = busy ? mem_addr : tb_addr;
    assign m_we     = busy & mem_we;
    assign mem_dout = mem[m_addr];

    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= mem_din;
    end

    function automatic logic [7:0] fib(input int j);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int i = 0; i < j; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the expected-output list.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_we", {31'd0, mem_we}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_err", {31'd0, err}, 32'd0);
                chk("rst_ck", {24'd0, checksum}, 32'd0);
                chk("rst_addr", {25'd0, mem_addr}, 32'd0);
            end else if (exp_q.size() > 0) begin
                cur_e = exp_q.pop_front();
                chk("cyc_busy", {31'd0, busy}, {31'd0, cur_e.busy});
                chk("cyc_we", {31'd0, mem_we}, {31'd0, cur_e.we});
                chk("cyc_done", {31'd0, done}, {31'd0, cur_e.done});
                chk("cyc_err", {31'd0, err}, {31'd0, cur_e.err});
                chk("cyc_ck", {24'd0, checksum}, {24'd0, cur_e.ck});
                if (cur_e.chk_addr) chk("cyc_addr", {25'd0, mem_addr}, {25'd0, cur_e.addr});
                if (cur_e.we) chk("cyc_din", {24'd0, mem_din}, {24'd0, cur_e.din});
            end else begin
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("idle_we", {31'd0, mem_we}, 32'd0);
                chk("idle_done", {31'd0, done}, 32'd0);
                chk("idle_err", {31'd0, err}, 32'd0);
                chk("idle_ck", {24'd0, checksum}, {24'd0, idle_ck});
            end
            if (done) done_cnt++;
        end
    end

    // Expected trace of a copy; only the first n_wr bytes land in exp_mem.
    task automatic push_copy(input logic [2:0] s, input logic [2:0] d, input int l, input int n_wr);
        exp_t e;
        logic [7:0] sum;
        logic [7:0] v;
        logic [6:0] ra;
        logic [6:0] wa;
        sum = 8'd0;
        for (int i = 0; i < l; i++) begin
            ra = {2'b00, s[1:0], i[2:0]};
            wa = {2'b10, d[1:0], i[2:0]};
            v  = exp_mem[ra];
            e = '{addr: ra, chk_addr: 1'b1, we: 1'b0, din: 8'd0,
                  busy: 1'b1, done: 1'b0, err: 1'b0, ck: sum};
            exp_q.push_back(e);
            e = '{addr: wa, chk_addr: 1'b1, we: 1'b1, din: v,
                  busy: 1'b1, done: 1'b0, err: 1'b0, ck: sum};
            exp_q.push_back(e);
            sum = sum + v;
            if (i < n_wr) exp_mem[wa] = v;
        end
        e = '{addr: 7'd0, chk_addr: 1'b0, we: 1'b0, din: 8'd0,
              busy: 1'b0, done: 1'b1, err: 1'b0, ck: sum};
        exp_q.push_back(e);
        idle_ck = sum;
    endtask

    // Drive a one-cycle start; expectations are queued on the same negedge.
    task automatic start_pulse(input logic [2:0] s, input logic [2:0] d, input logic [3:0] l,
                               input int n_wr);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        src_bank = s;
        dst_bank = d;
        len      = l;
        if (l >= 4'd1 && l <= 4'd8) begin
            push_copy(s, d, int'(l), n_wr);
        end else begin
            e = '{addr: 7'd0, chk_addr: 1'b0, we: 1'b0, din: 8'd0,
                  busy: 1'b0, done: 1'b0, err: 1'b1, ck: idle_ck};
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_sram();
        for (int a = 64; a < 96; a++) begin
            @(negedge clk);
            tb_addr = a[6:0];
            #1;
            chk("sram_rd", {24'd0, mem_dout}, {24'd0, exp_mem[a]});
        end
    endtask

    initial begin
        logic [7:0] fib_lit [0:7];
        int d0;
        fib_lit = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21};
        total = 0; bad = 0; done_cnt = 0; idle_ck = 8'd0;
        start = 1'b0; src_bank = 3'd0; dst_bank = 3'd0; len = 4'd0; tb_addr = 7'd0;
        for (int a = 0; a < 128; a++) begin
            mem[a]     = (a < 32) ? fib(a % 8) + 8'(a / 8) : 8'hEE;
            exp_mem[a] = mem[a];
        end

        // Reset asserted mid-cycle clears outputs at once.
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("por_busy", {31'd0, busy}, 32'd0);
        chk("por_we", {31'd0, mem_we}, 32'd0);
        chk("por_ck", {24'd0, checksum}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-bank copy ROM bank 0 -> SRAM bank 2.
        d0 = done_cnt;
        start_pulse(3'd0, 3'd2, 4'd8, 8);
        wait_idle();
        chk("full_ck_lit", {24'd0, checksum}, 32'd54);
        chk("full_done_cnt", done_cnt - d0, 32'd1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            tb_addr = 7'd80 + j[6:0];
            #1;
            chk("full_word_lit", {24'd0, mem_dout}, {24'd0, fib_lit[j]});
        end

        // Partial copy ROM bank 3 -> bank index 5.
        start_pulse(3'd3, 3'd5, 4'd4, 4);
        wait_idle();
        chk("part_ck_lit", {24'd0, checksum}, 32'd19);
        @(negedge clk);
        tb_addr = 7'd76;
        #1;
        chk("part_w4_lit", {24'd0, mem_dout}, 32'hEE);
        check_sram();

        // Rejected lengths.
        start_pulse(3'd1, 3'd1, 4'd0, 0);
        wait_idle();
        start_pulse(3'd1, 3'd1, 4'd9, 0);
        wait_idle();
        chk("illegal_ck_lit", {24'd0, checksum}, 32'd19);

        // A second start during a copy is ignored.
        d0 = done_cnt;
        start_pulse(3'd2, 3'd4, 4'd3, 3);
        @(negedge clk);
        start = 1'b1; src_bank = 3'd0; dst_bank = 3'd7; len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("busy_ck_lit", {24'd0, checksum}, 32'd10);
        chk("busy_done_cnt", done_cnt - d0, 32'd1);
        check_sram();

        // Reset during the third WRITE of an 8-byte copy.
        d0 = done_cnt;
        start_pulse(3'd1, 3'd3, 4'd8, 2);
        repeat (5) @(negedge clk);
        chk("abort_in_write", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_ck", {24'd0, checksum}, 32'd0);
        exp_q.delete();
        idle_ck = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        check_sram();

        // A fresh copy after the abort completes normally.
        start_pulse(3'd0, 3'd3, 4'd8, 8);
        wait_idle();
        chk("post_ck_lit", {24'd0, checksum}, 32'd54);
        check_sram();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
